period_meter: RTL and testbench

//  Receive-side counterpart of the LED clock divider: samples a slow square wave (divider

---
 rtl/period_meter_if.sv | 34 +++
 rtl/period_meter.sv | 169 ++++++++++++++++
 tb/tb_period_meter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// period_meter_if
//   Groups the measurement controls and results of period_meter.
//   Parameter CNT_W : width of the period/high-time results.
//   Signals:
//     en         measurement enable (driven by the controller)
//     sig_in     asynchronous waveform to measure (driven by the controller)
//     period_out last period, rise-to-rise, in clk cycles
//     high_out   last high time, rise-to-fall, in clk cycles
//     valid      one-cycle pulse when period_out/high_out update
//     locked     two consecutive periods were equal
//     ovf        sticky period overflow flag
//   master: the side that enables and supplies the waveform
//   slave : the meter itself
interface period_meter_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             locked;
  logic             ovf;

  modport master (
    output en, sig_in,
    input  period_out, high_out, valid, locked, ovf
  );

  modport slave (
    input  en, sig_in,
    output period_out, high_out, valid, locked, ovf
  );
endinterface

// File: rtl/period_meter.sv
// period_meter
//   Measures the period (rise to rise) and high time (rise to fall) of a slow
//   asynchronous square wave in clk cycles, and reports lock when two
//   consecutive periods are equal. A period longer than 2^CNT_W-1 cycles
//   raises a sticky overflow flag and re-arms the meter.
//   Parameters:
//     CNT_W       width of counters and results
//     SYNC_STAGES synchronizer depth on sig_in (>= 2)
//   Ports:
//     clk  system clock
//     rst  asynchronous reset, active-high
//     bus  period_meter_if slave modport (en, sig_in in; results out)
module period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  period_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   s_s;
  logic                   rise_s;

  state_t           state_r, state_n;
  logic [CNT_W-1:0] pcnt_r, pcnt_n;
  logic [CNT_W-1:0] hcnt_r, hcnt_n;
  logic [CNT_W-1:0] period_r, period_n;
  logic [CNT_W-1:0] high_r, high_n;
  logic             valid_r, valid_n;
  logic             locked_r, locked_n;
  logic             ovf_r, ovf_n;
  // Set once a period has been reported since the last ARM, so the first
  // report after arming never claims lock against a stale period_out.
  logic             have_r, have_n;

  assign s_s    = sync_r[SYNC_STAGES-1];
  assign rise_s = s_s & ~prev_r;

  // Synchronizer chain and one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.sig_in};
      prev_r <= s_s;
    end
  end

  // Next-state and next-value logic for the FSM and the measurement datapath.
  always_comb begin
    state_n  = state_r;
    pcnt_n   = pcnt_r;
    hcnt_n   = hcnt_r;
    period_n = period_r;
    high_n   = high_r;
    valid_n  = 1'b0;
    locked_n = locked_r;
    ovf_n    = ovf_r;
    have_n   = have_r;

    if (!bus.en) begin
      // Disabling discards any measurement in progress; results are held.
      state_n  = IDLE;
      pcnt_n   = '0;
      hcnt_n   = '0;
      locked_n = 1'b0;
      ovf_n    = 1'b0;
      have_n   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_n = ARM;
          pcnt_n  = '0;
          hcnt_n  = '0;
          have_n  = 1'b0;
        end
        ARM: begin
          // The partial period before the first rise is never measured.
          if (rise_s) begin
            state_n = MEAS;
            pcnt_n  = CNT_ONE;
            hcnt_n  = CNT_ONE;
          end else begin
            state_n = ARM;
          end
        end
        MEAS: begin
          if (rise_s) begin
            period_n = pcnt_r;
            high_n   = hcnt_r;
            valid_n  = 1'b1;
            pcnt_n   = CNT_ONE;
            hcnt_n   = CNT_ONE;
            locked_n = have_r & (pcnt_r == period_r);
            have_n   = 1'b1;
          end else if (pcnt_r == CNT_MAX) begin
            // Counter would wrap: flag it and start over from a fresh rise.
            state_n  = ARM;
            ovf_n    = 1'b1;
            locked_n = 1'b0;
            have_n   = 1'b0;
            pcnt_n   = '0;
            hcnt_n   = '0;
          end else begin
            pcnt_n = pcnt_r + CNT_ONE;
            // High time freezes after the fall until the next rise.
            if (s_s) begin
              hcnt_n = hcnt_r + CNT_ONE;
            end else begin
              hcnt_n = hcnt_r;
            end
          end
        end
        default: begin
          state_n  = IDLE;
          pcnt_n   = '0;
          hcnt_n   = '0;
          locked_n = 1'b0;
          have_n   = 1'b0;
        end
      endcase
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      pcnt_r   <= '0;
      hcnt_r   <= '0;
      period_r <= '0;
      high_r   <= '0;
      valid_r  <= 1'b0;
      locked_r <= 1'b0;
      ovf_r    <= 1'b0;
      have_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      pcnt_r   <= pcnt_n;
      hcnt_r   <= hcnt_n;
      period_r <= period_n;
      high_r   <= high_n;
      valid_r  <= valid_n;
      locked_r <= locked_n;
      ovf_r    <= ovf_n;
      have_r   <= have_n;
    end
  end

  assign bus.period_out = period_r;
  assign bus.high_out   = high_r;
  assign bus.valid      = valid_r;
  assign bus.locked     = locked_r;
  assign bus.ovf        = ovf_r;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
//   Drives two period_meter instances (CNT_W=16 and CNT_W=4) with directed
//   waveforms. Expected reports are queued before the stimulus that causes
//   them; per-instance monitors pop and compare on every valid pulse.
module tb_period_meter;

  typedef struct {
    int p;
    int h;
    int l;
  } exp_t;

  logic clk;
  logic rst;

  period_meter_if #(.CNT_W(16)) b16 ();
  period_meter_if #(.CNT_W(4))  b4 ();

  period_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  period_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  exp_t q16[$];
  exp_t q4[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_valid16 = 0;
  int   n_valid4  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int which, input int p, input int h, input int l);
    exp_t e;
    e.p = p;
    e.h = h;
    e.l = l;
    if (which == 16) q16.push_back(e);
    else             q4.push_back(e);
  endtask

  // Set sig_in at the current negedge and hold it for n cycles.
  task automatic drive(input int which, input logic v, input int n);
    if (which == 16) b16.sig_in = v;
    else             b4.sig_in  = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int which, input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      drive(which, 1'b1, hi);
      drive(which, 1'b0, lo);
    end
  endtask

  // One more rise to close the last full period, then settle low.
  task automatic tail(input int which, input int hi);
    drive(which, 1'b1, hi);
    drive(which, 1'b0, 4);
  endtask

  task automatic set_en(input int which, input logic v, input int n);
    if (which == 16) b16.en = v;
    else             b4.en  = v;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && b16.valid) begin
      n_valid16++;
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid16: got period %0d high %0d, expected no valid",
                 b16.period_out, b16.high_out);
      end else begin
        e = q16.pop_front();
        check("period16", int'(b16.period_out), e.p);
        check("high16",   int'(b16.high_out),   e.h);
        check("locked16", int'(b16.locked),     e.l);
      end
    end
  end

  // Scoreboard monitor for the 4-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && b4.valid) begin
      n_valid4++;
      if (q4.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid4: got period %0d high %0d, expected no valid",
                 b4.period_out, b4.high_out);
      end else begin
        e = q4.pop_front();
        check("period4", int'(b4.period_out), e.p);
        check("high4",   int'(b4.high_out),   e.h);
        check("locked4", int'(b4.locked),     e.l);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst       = 1'b1;
    b16.en    = 1'b0;
    b16.sig_in = 1'b0;
    b4.en     = 1'b0;
    b4.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", int'(b16.period_out), 0);
    check("rst_high",   int'(b16.high_out),   0);
    check("rst_valid",  int'(b16.valid),      0);
    check("rst_locked", int'(b16.locked),     0);
    check("rst_ovf",    int'(b16.ovf),        0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 10-cycle period, 5 high
    set_en(16, 1'b1, 2);
    push(16, 10, 5, 0);
    push(16, 10, 5, 1);
    wave(16, 5, 5, 2);
    tail(16, 5);
    set_en(16, 1'b0, 3);
    check("t1_hold_period", int'(b16.period_out), 10);
    check("t1_idle_locked", int'(b16.locked), 0);

    // 2: period 7, high 3
    set_en(16, 1'b1, 2);
    push(16, 7, 3, 0);
    push(16, 7, 3, 1);
    wave(16, 3, 4, 2);
    tail(16, 3);
    set_en(16, 1'b0, 3);

    // 3: period 10 then 12
    set_en(16, 1'b1, 2);
    push(16, 10, 5, 0);
    push(16, 10, 5, 1);
    push(16, 10, 5, 1);
    push(16, 12, 6, 0);
    push(16, 12, 6, 1);
    wave(16, 5, 5, 3);
    wave(16, 6, 6, 2);
    tail(16, 6);
    set_en(16, 1'b0, 3);

    // 5: en dropped mid-period
    set_en(16, 1'b1, 2);
    push(16, 10, 5, 0);
    push(16, 10, 5, 1);
    wave(16, 5, 5, 2);
    drive(16, 1'b1, 5);
    drive(16, 1'b0, 2);
    set_en(16, 1'b0, 3);
    check("t5_locked", int'(b16.locked), 0);
    check("t5_ovf",    int'(b16.ovf), 0);
    check("t5_period", int'(b16.period_out), 10);
    check("t5_high",   int'(b16.high_out), 5);
    set_en(16, 1'b1, 3);
    nv = n_valid16;
    wave(16, 5, 5, 1);
    check("t5_no_valid_first_rise", n_valid16 - nv, 0);
    push(16, 10, 5, 0);
    push(16, 10, 5, 1);
    wave(16, 5, 5, 1);
    tail(16, 5);
    set_en(16, 1'b0, 3);

    // 6: asynchronous reset mid-measurement
    set_en(16, 1'b1, 2);
    push(16, 10, 5, 0);
    push(16, 10, 5, 1);
    wave(16, 5, 5, 2);
    drive(16, 1'b1, 5);
    drive(16, 1'b0, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    b16.sig_in = 1'b0;
    #1;
    check("t6_period", int'(b16.period_out), 0);
    check("t6_high",   int'(b16.high_out), 0);
    check("t6_valid",  int'(b16.valid), 0);
    check("t6_locked", int'(b16.locked), 0);
    check("t6_ovf",    int'(b16.ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(16, 1'b0, 3);
    push(16, 10, 5, 0);
    push(16, 10, 5, 1);
    wave(16, 5, 5, 2);
    tail(16, 5);
    set_en(16, 1'b0, 3);

    // 4: CNT_W=4 overflow with input stuck low after one rise
    set_en(4, 1'b1, 2);
    drive(4, 1'b1, 2);
    drive(4, 1'b0, 15);
    check("t4_ovf_before", int'(b4.ovf), 0);
    drive(4, 1'b0, 1);
    check("t4_ovf_set", int'(b4.ovf), 1);
    check("t4_locked",  int'(b4.locked), 0);
    drive(4, 1'b0, 5);
    check("t4_ovf_sticky", int'(b4.ovf), 1);
    check("t4_no_valid", n_valid4, 0);
    // Re-armed: first rise only arms, second reports.
    push(4, 6, 3, 0);
    push(4, 6, 3, 1);
    wave(4, 3, 3, 2);
    tail(4, 3);
    check("t4_ovf_still", int'(b4.ovf), 1);
    set_en(4, 1'b0, 2);
    check("t4_ovf_cleared", int'(b4.ovf), 0);

    check("q16_drained", q16.size(), 0);
    check("q4_drained",  q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
